// File: rtl/adc_spi_master.sv
// adc_spi_master
//   SPI master for ADC register access. One START shifts a {RW, ADDR, DATA} frame
//   MSB-first in SPI mode 0. The block also produces a timed active-low ADC reset
//   pulse and an independent active-high SYNC pulse.
//
// Ports
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_start               one-cycle command strobe (i_rw, i_addr, i_wr_data, i_cs_sel sampled with it)
//   i_rstn_req            one-cycle strobe: pulse o_adc_rstn low for RSTN_CYCLES
//   i_sync_req            one-cycle strobe: pulse o_adc_sync high for SYNC_CYCLES (retriggerable)
//   o_busy                transfer or reset pulse in progress
//   o_done                one-cycle pulse at the end of a transfer
//   o_err                 one-cycle pulse when a START names a nonexistent chip select
//   o_rd_data             data word captured by the most recent read
//   i_adc_miso            serial data from the ADC
//   o_adc_sclk/o_adc_mosi SPI clock (idle low) and data to the ADC
//   o_adc_csn             active-low chip selects, one per ADC
//   o_adc_rstn            active-low ADC reset
//   o_adc_sync            single-ended SYNC, active high
//
// i_cs_sel is one bit wider than strictly needed when N_CS is a power of two so
// that out-of-range selects can be expressed and rejected with o_err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for START / RSTN_REQ, SPI pins idle
// S_SHIFT | frame shifting, CLK_DIV cycles SCLK low then CLK_DIV high per bit
// S_HOLD  | CLK_DIV cycles SCLK low with chip select still asserted
// S_GAP   | CLK_DIV cycles with all chip selects released
// S_RSTP  | ADC reset pulse, o_adc_rstn low for RSTN_CYCLES cycles

module adc_spi_master #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 4,
    parameter int N_CS        = 1,
    parameter int RSTN_CYCLES = 16,
    parameter int SYNC_CYCLES = 8,
    localparam int FRAME_W    = 1 + ADDR_W + DATA_W,
    localparam int CS_W       = $clog2(N_CS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic              i_rstn_req,
    input  logic              i_sync_req,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_adc_miso,
    output logic              o_adc_sclk,
    output logic              o_adc_mosi,
    output logic [N_CS-1:0]   o_adc_csn,
    output logic              o_adc_rstn,
    output logic              o_adc_sync
);

    localparam int TMR_MAX = (CLK_DIV > RSTN_CYCLES) ? CLK_DIV : RSTN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int SYNC_W  = $clog2(SYNC_CYCLES + 1);

    localparam logic [TMR_W-1:0]  DIV_LOAD  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]  RSTN_LOAD = TMR_W'(RSTN_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(FRAME_W - 1);
    localparam logic [SYNC_W-1:0] SYNC_LOAD = SYNC_W'(SYNC_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RSTP  = 3'd4;

    logic [2:0]         r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic [BIT_W-1:0]   r_bit_cnt;
    // Holds the not-yet-sent frame bits; received bits enter at the LSB, so after
    // the last bit the low DATA_W bits are the read word.
    logic [FRAME_W-2:0] r_shift;
    logic               r_rw;
    logic               r_sclk;
    logic               r_mosi;
    logic [N_CS-1:0]    r_csn;
    logic               r_rstn;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_sync;
    logic [SYNC_W-1:0]  r_sync_cnt;

    logic [FRAME_W-1:0] w_frame;
    logic [N_CS-1:0]    w_csn_sel;
    logic               w_cs_ok;

    // Read frames send zeros in the data field.
    assign w_frame   = {i_rw, i_addr, (i_rw ? {DATA_W{1'b0}} : i_wr_data)};
    assign w_csn_sel = ~(N_CS'(1) << i_cs_sel);
    assign w_cs_ok   = (i_cs_sel < CS_W'(N_CS));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_csn     <= '1;
            r_rstn    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rstn_req) begin
                        r_state <= S_RSTP;
                        r_tmr   <= RSTN_LOAD;
                        r_rstn  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (i_start) begin
                        if (w_cs_ok) begin
                            r_state   <= S_SHIFT;
                            r_tmr     <= DIV_LOAD;
                            r_bit_cnt <= BIT_LOAD;
                            r_shift   <= w_frame[FRAME_W-2:0];
                            r_mosi    <= w_frame[FRAME_W-1];
                            r_rw      <= i_rw;
                            r_csn     <= w_csn_sel;
                            r_busy    <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else begin
                        r_tmr <= DIV_LOAD;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // End of the last high cycle: sample MISO, drop SCLK and
                            // present the next bit in the first low cycle.
                            r_sclk  <= 1'b0;
                            r_shift <= {r_shift[FRAME_W-3:0], i_adc_miso};
                            if (r_bit_cnt == '0) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 1'b1;
                                r_mosi    <= r_shift[FRAME_W-2];
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else begin
                        r_tmr   <= DIV_LOAD;
                        r_state <= S_GAP;
                        r_csn   <= '1;
                        r_mosi  <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_rw) begin
                            r_rd_data <= r_shift[DATA_W-1:0];
                        end
                    end
                end
                S_RSTP: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_rstn  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_csn   <= '1;
                    r_rstn  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // SYNC pulse runs independently of the SPI state machine; a new request
    // reloads the count so the pulse stretches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync     <= 1'b0;
            r_sync_cnt <= '0;
        end else if (i_sync_req) begin
            r_sync     <= 1'b1;
            r_sync_cnt <= SYNC_LOAD;
        end else if (r_sync) begin
            if (r_sync_cnt == '0) begin
                r_sync <= 1'b0;
            end else begin
                r_sync_cnt <= r_sync_cnt - 1'b1;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rd_data  = r_rd_data;
    assign o_adc_sclk = r_sclk;
    assign o_adc_mosi = r_mosi;
    assign o_adc_csn  = r_csn;
    assign o_adc_rstn = r_rstn;
    assign o_adc_sync = r_sync;

endmodule

// File: tb/tb_adc_spi_master.sv
module tb_adc_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: default parameters
    logic       rst_a, start_a, rw_a, rstn_req_a, sync_req_a, miso_a;
    logic [6:0] addr_a;
    logic [7:0] wd_a, rd_a;
    logic [0:0] cs_a, csn_a;
    logic       busy_a, done_a, err_a, sclk_a, mosi_a, rstn_a, sync_a;

    // instance B: CLK_DIV=1, N_CS=2
    logic       rst_b, start_b, rw_b, rstn_req_b, sync_req_b, miso_b;
    logic [6:0] addr_b;
    logic [7:0] wd_b, rd_b;
    logic [1:0] cs_b, csn_b;
    logic       busy_b, done_b, err_b, sclk_b, mosi_b, rstn_b, sync_b;

    adc_spi_master u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_rw(rw_a), .i_addr(addr_a),
        .i_wr_data(wd_a), .i_cs_sel(cs_a), .i_rstn_req(rstn_req_a), .i_sync_req(sync_req_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_rd_data(rd_a),
        .i_adc_miso(miso_a), .o_adc_sclk(sclk_a), .o_adc_mosi(mosi_a), .o_adc_csn(csn_a),
        .o_adc_rstn(rstn_a), .o_adc_sync(sync_a)
    );

    adc_spi_master #(.CLK_DIV(1), .N_CS(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_rw(rw_b), .i_addr(addr_b),
        .i_wr_data(wd_b), .i_cs_sel(cs_b), .i_rstn_req(rstn_req_b), .i_sync_req(sync_req_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_rd_data(rd_b),
        .i_adc_miso(miso_b), .o_adc_sclk(sclk_b), .o_adc_mosi(mosi_b), .o_adc_csn(csn_b),
        .o_adc_rstn(rstn_b), .o_adc_sync(sync_b)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] mosi;
        logic [7:0]  rd;
        int          t0;
        int          lat;
        int          cs_mask;
    } exp_t;

    typedef struct {
        int t0;
        int len;
    } pulse_t;

    exp_t   q_a[$], q_b[$];
    pulse_t q_rstn[$], q_sync[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // ---------------- monitor + ADC model, instance A ----------------
    logic        ps_a = 1'b0;
    logic [0:0]  pcsn_a = 1'b1;
    logic [15:0] sh_a = '0;
    logic [7:0]  resp_a = '0;
    logic [0:0]  csl_a = '0;
    int          rises_a = 0, lr_a = 0, bit_a = 0;
    bit          per_ok_a = 1'b1;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (&pcsn_a && !(&csn_a)) begin
            rises_a = 0; sh_a = '0; csl_a = '0; per_ok_a = 1'b1;
        end
        csl_a = csl_a | ~csn_a;
        if (sclk_a && !ps_a) begin
            if (rises_a > 0 && (cyc - lr_a) != 8) per_ok_a = 1'b0;
            lr_a = cyc;
            rises_a++;
            sh_a = {sh_a[14:0], mosi_a};
        end
        if (!rst_a && (done_a || err_a)) begin
            if (q_a.size() == 0) check("a_unexpected_done_err", q_a.size(), 1);
            else begin
                e = q_a.pop_front();
                check("a_err_flag", err_a, e.is_err);
                check("a_done_flag", done_a, !e.is_err);
                check("a_latency", cyc - e.t0, e.lat);
                check("a_busy_at_end", busy_a, 0);
                check("a_csn_at_end", csn_a, 1);
                if (!e.is_err) begin
                    check("a_mosi_stream", sh_a, e.mosi);
                    check("a_sclk_rises", rises_a, 16);
                    check("a_sclk_period", per_ok_a, 1);
                    check("a_rd_data", rd_a, e.rd);
                    check("a_cs_mask", csl_a, e.cs_mask);
                end
            end
        end
        // ADC model: bit index advances on each SCLK fall; data bits come from resp_a
        if (&csn_a) bit_a = 0;
        else if (ps_a && !sclk_a) bit_a++;
        miso_a = (bit_a >= 8 && bit_a < 16) ? resp_a[15 - bit_a] : 1'b1;
        ps_a   = sclk_a;
        pcsn_a = csn_a;
    end

    // ---------------- monitor, instance B ----------------
    logic        ps_b = 1'b0;
    logic [1:0]  pcsn_b = 2'b11;
    logic [15:0] sh_b = '0;
    logic [1:0]  csl_b = '0;
    int          rises_b = 0, lr_b = 0;
    bit          per_ok_b = 1'b1;

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (&pcsn_b && !(&csn_b)) begin
            rises_b = 0; sh_b = '0; csl_b = '0; per_ok_b = 1'b1;
        end
        csl_b = csl_b | ~csn_b;
        if (sclk_b && !ps_b) begin
            if (rises_b > 0 && (cyc - lr_b) != 2) per_ok_b = 1'b0;
            lr_b = cyc;
            rises_b++;
            sh_b = {sh_b[14:0], mosi_b};
        end
        if (!rst_b && (done_b || err_b)) begin
            if (q_b.size() == 0) check("b_unexpected_done_err", q_b.size(), 1);
            else begin
                e = q_b.pop_front();
                check("b_err_flag", err_b, e.is_err);
                check("b_done_flag", done_b, !e.is_err);
                check("b_latency", cyc - e.t0, e.lat);
                check("b_busy_at_end", busy_b, 0);
                check("b_csn_at_end", csn_b, 3);
                if (!e.is_err) begin
                    check("b_mosi_stream", sh_b, e.mosi);
                    check("b_sclk_rises", rises_b, 16);
                    check("b_sclk_period", per_ok_b, 1);
                    check("b_rd_data", rd_b, e.rd);
                    check("b_cs_mask", csl_b, e.cs_mask);
                end
            end
        end
        ps_b   = sclk_b;
        pcsn_b = csn_b;
    end

    // ---------------- pulse monitor, instance A RSTN / SYNC ----------------
    int run_r = 0, st_r = 0, run_s = 0, st_s = 0;

    always @(negedge clk) begin : mon_pulse
        pulse_t p;
        if (!rst_a) begin
            if (!rstn_a) begin
                if (run_r == 0) st_r = cyc;
                run_r++;
            end else if (run_r > 0) begin
                if (q_rstn.size() == 0) check("rstn_unexpected_pulse", q_rstn.size(), 1);
                else begin
                    p = q_rstn.pop_front();
                    check("rstn_start", st_r - p.t0, 1);
                    check("rstn_len", run_r, p.len);
                end
                run_r = 0;
            end
            if (sync_a) begin
                if (run_s == 0) st_s = cyc;
                run_s++;
            end else if (run_s > 0) begin
                if (q_sync.size() == 0) check("sync_unexpected_pulse", q_sync.size(), 1);
                else begin
                    p = q_sync.pop_front();
                    check("sync_start", st_s - p.t0, 1);
                    check("sync_len", run_s, p.len);
                end
                run_s = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic cmd_a(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                         input logic [15:0] frame, input logic [7:0] rd_exp, output int t);
        step();
        start_a = 1'b1; rw_a = rw; addr_a = addr; wd_a = data; cs_a = '0;
        t = cyc;
        q_a.push_back(exp_t'{1'b0, frame, rd_exp, t, 137, 1});
        step();
        start_a = 1'b0;
        check("a_busy_t1", busy_a, 1);
        check("a_csn_t1", csn_a, 0);
        check("a_mosi_t1", mosi_a, frame[15]);
    endtask

    task automatic cmd_b(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                         input logic [1:0] cs, input logic [1:0] csn_exp, input int mask,
                         input logic [15:0] frame, input logic [7:0] rd_exp,
                         input bit push, output int t);
        step();
        start_b = 1'b1; rw_b = rw; addr_b = addr; wd_b = data; cs_b = cs;
        t = cyc;
        if (push) q_b.push_back(exp_t'{1'b0, frame, rd_exp, t, 35, mask});
        step();
        start_b = 1'b0;
        check("b_busy_t1", busy_b, 1);
        check("b_csn_t1", csn_b, csn_exp);
        check("b_mosi_t1", mosi_b, frame[15]);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_a.size() + q_b.size() + q_rstn.size() + q_sync.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_queues", q_a.size() + q_b.size() + q_rstn.size() + q_sync.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, t2;
        rst_a = 1'b1; start_a = 1'b0; rw_a = 1'b0; addr_a = '0; wd_a = '0; cs_a = '0;
        rstn_req_a = 1'b0; sync_req_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; rw_b = 1'b0; addr_b = '0; wd_b = '0; cs_b = '0;
        rstn_req_b = 1'b0; sync_req_b = 1'b0; miso_b = 1'b1;
        resp_a = 8'hC3;
        repeat (3) step();
        rst_a = 1'b0; rst_b = 1'b0;

        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_csn", csn_a, 1);
        check("rst_rstn", rstn_a, 1);
        check("rst_sync", sync_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_rd_data", rd_a, 0);
        check("rst_b_csn", csn_b, 3);
        check("rst_b_rstn", rstn_b, 1);
        check("rst_b_sync", sync_b, 0);

        // write 0x12 <- 0x5A; ADC drives 0xC3 which must not reach RD_DATA
        cmd_a(1'b0, 7'h12, 8'h5A, 16'h125A, 8'h00, t);
        drain(400);

        // read 0x05, ADC returns 0xA5; write-data input must not appear on MOSI
        resp_a = 8'hA5;
        cmd_a(1'b1, 7'h05, 8'hFF, 16'h8500, 8'hA5, t);
        drain(400);

        // write with stray START and RSTN_REQ while busy, then back-to-back read in the DONE cycle
        resp_a = 8'h3C;
        cmd_a(1'b0, 7'h7F, 8'h01, 16'h7F01, 8'hA5, t);
        wait_until(t + 10);
        start_a = 1'b1; rw_a = 1'b1; addr_a = 7'h11;
        step();
        start_a = 1'b0;
        wait_until(t + 20);
        rstn_req_a = 1'b1;
        step();
        rstn_req_a = 1'b0;
        check("a_busy_mid", busy_a, 1);
        wait_until(t + 136);
        cmd_a(1'b1, 7'h2A, 8'h00, 16'hAA00, 8'h3C, t2);
        check("a_b2b_start_cycle", t2 - t, 137);
        drain(400);

        // RSTN_REQ together with START: reset pulse wins, START dropped
        step();
        rstn_req_a = 1'b1; start_a = 1'b1; rw_a = 1'b0; addr_a = 7'h01; wd_a = 8'h02;
        t = cyc;
        q_rstn.push_back(pulse_t'{t, 16});
        step();
        rstn_req_a = 1'b0; start_a = 1'b0;
        check("a_rstp_rstn_t1", rstn_a, 0);
        check("a_rstp_busy_t1", busy_a, 1);
        check("a_rstp_csn_t1", csn_a, 1);
        check("a_rstp_sclk_t1", sclk_a, 0);
        wait_until(t + 16);
        check("a_rstp_busy_last", busy_a, 1);
        step();
        check("a_rstp_busy_after", busy_a, 0);
        check("a_rstp_rstn_after", rstn_a, 1);
        drain(100);

        // SYNC pulse, then a retrigger 3 cycles in stretching it to 11
        step();
        sync_req_a = 1'b1;
        q_sync.push_back(pulse_t'{cyc, 8});
        step();
        sync_req_a = 1'b0;
        check("a_sync_t1", sync_a, 1);
        drain(100);
        step();
        sync_req_a = 1'b1;
        t = cyc;
        q_sync.push_back(pulse_t'{t, 11});
        step();
        sync_req_a = 1'b0;
        wait_until(t + 3);
        sync_req_a = 1'b1;
        step();
        sync_req_a = 1'b0;
        drain(100);

        // instance B: out-of-range chip select rejected
        step();
        start_b = 1'b1; rw_b = 1'b0; cs_b = 2'd3;
        q_b.push_back(exp_t'{1'b1, 16'h0, 8'h00, cyc, 1, 0});
        step();
        start_b = 1'b0;
        check("b_err_csn_t1", csn_b, 3);
        check("b_err_busy_t1", busy_b, 0);
        drain(50);

        // read on CS 1 with MISO held high, then a write that leaves RD_DATA alone
        cmd_b(1'b1, 7'h33, 8'h00, 2'd1, 2'b01, 2, 16'hB300, 8'hFF, 1'b1, t);
        drain(100);
        cmd_b(1'b0, 7'h12, 8'h5A, 2'd1, 2'b01, 2, 16'h125A, 8'hFF, 1'b1, t);
        drain(100);

        // RST in the middle of SHIFT
        cmd_b(1'b0, 7'h40, 8'h80, 2'd0, 2'b10, 1, 16'h4080, 8'hFF, 1'b0, t);
        wait_until(t + 9);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        check("b_abort_csn", csn_b, 3);
        check("b_abort_busy", busy_b, 0);
        check("b_abort_rd", rd_b, 0);
        check("b_abort_sclk", sclk_b, 0);
        check("b_abort_mosi", mosi_b, 0);
        repeat (60) step();
        check("b_abort_busy_later", busy_b, 0);
        check("b_abort_csn_later", csn_b, 3);
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
